// File: rtl/branch_predict_ctrl_if.sv
// Pipeline-side bundle for the branch predictor/resolver: IF prediction lookup,
// EX resolution inputs, redirect/flush outputs and branch statistics.
interface branch_predict_ctrl_if;
    logic        if_valid;
    logic        if_is_branch;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_stall;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_br_taken;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    modport slave (
        input  if_valid, if_is_branch, if_pc,
        input  ex_valid, ex_is_branch, ex_stall, ex_pc, ex_pred_taken, ex_br_taken, ex_target,
        output pred_taken, redirect_valid, redirect_pc, flush, branch_cnt, mispredict_cnt
    );

    modport master (
        output if_valid, if_is_branch, if_pc,
        output ex_valid, ex_is_branch, ex_stall, ex_pc, ex_pred_taken, ex_br_taken, ex_target,
        input  pred_taken, redirect_valid, redirect_pc, flush, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// 2-bit saturating-counter branch predictor with EX-stage resolution,
// mispredict redirect and two-cycle flush sequencing, plus branch statistics.
module branch_predict_ctrl #(
    parameter int unsigned ENTRIES  = 16,
    parameter logic [1:0]  INIT_CTR = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_predict_ctrl_if.slave bp
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {IDLE, FLUSH1, FLUSH2} state_e;

    state_e          state_q, state_d;
    logic [1:0]      ctr_q [ENTRIES];
    logic [1:0]      ctr_d [ENTRIES];
    logic            redirect_valid_q, redirect_valid_d;
    logic [31:0]     redirect_pc_q, redirect_pc_d;
    logic            flush_q, flush_d;
    logic [31:0]     branch_cnt_q, branch_cnt_d;
    logic [31:0]     mispredict_cnt_q, mispredict_cnt_d;
    logic            res, mis;
    logic [IDX_W-1:0] if_idx, ex_idx;
    logic            unused_pc_bits;

    assign if_idx = bp.if_pc[IDX_W+1:2];
    assign ex_idx = bp.ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{bp.if_pc[31:IDX_W+2], bp.if_pc[1:0]};

    // Prediction reads the registered table, so same-cycle updates are not visible yet.
    assign bp.pred_taken = bp.if_valid & bp.if_is_branch & ctr_q[if_idx][1];

    always_comb begin
        state_d          = state_q;
        ctr_d            = ctr_q;
        redirect_pc_d    = redirect_pc_q;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;

        res = (state_q == IDLE) & bp.ex_valid & bp.ex_is_branch & ~bp.ex_stall;
        mis = res & (bp.ex_br_taken != bp.ex_pred_taken);

        if (res) begin
            if (bp.ex_br_taken) begin
                if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
            end else begin
                if (ctr_q[ex_idx] != 2'b00) ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
            end
        end

        branch_cnt_d     = branch_cnt_q + 32'(res);
        mispredict_cnt_d = mispredict_cnt_q + 32'(mis);

        if (mis) redirect_pc_d = bp.ex_br_taken ? bp.ex_target : bp.ex_pc + 32'd4;

        case (state_q)
            IDLE:    if (mis) state_d = FLUSH1;
            FLUSH1:  state_d = FLUSH2;
            FLUSH2:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        redirect_valid_d = (state_d == FLUSH1);
        flush_d          = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= INIT_CTR;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            flush_q          <= 1'b0;
            branch_cnt_q     <= 32'd0;
            mispredict_cnt_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            ctr_q            <= ctr_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign bp.redirect_valid = redirect_valid_q;
    assign bp.redirect_pc    = redirect_pc_q;
    assign bp.flush          = flush_q;
    assign bp.branch_cnt     = branch_cnt_q;
    assign bp.mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed scenarios plus randomized
// traffic against a table/countdown reference model.
module tb_branch_predict_ctrl;
    localparam int unsigned ENTRIES = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predict_ctrl_if bp_if();

    branch_predict_ctrl #(.ENTRIES(ENTRIES), .INIT_CTR(2'b01)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: counter values, remaining flush cycles, expected registers.
    int          m_ctr [ENTRIES];
    int          m_flush_left;
    logic [31:0] m_rpc, m_bc, m_mc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic logic m_pred();
        return bp_if.if_valid && bp_if.if_is_branch && (m_ctr[idx_of(bp_if.if_pc)] >= 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) m_ctr[i] = 1;
        m_flush_left = 0;
        m_rpc = 0; m_bc = 0; m_mc = 0;
    endtask

    task automatic model_edge();
        bit res, mis;
        int k;
        res = (m_flush_left == 0) && bp_if.ex_valid && bp_if.ex_is_branch && !bp_if.ex_stall;
        mis = res && (bp_if.ex_br_taken != bp_if.ex_pred_taken);
        if (res) begin
            k = idx_of(bp_if.ex_pc);
            if (bp_if.ex_br_taken) m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
            else                   m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
            m_bc = m_bc + 1;
        end
        if (mis) begin
            m_mc  = m_mc + 1;
            m_rpc = bp_if.ex_br_taken ? bp_if.ex_target : bp_if.ex_pc + 32'd4;
        end
        if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
        else if (mis)         m_flush_left = 2;
    endtask

    task automatic check_outs();
        check_val("redirect_valid", 32'(bp_if.redirect_valid), 32'(m_flush_left == 2));
        check_val("flush",          32'(bp_if.flush),          32'(m_flush_left != 0));
        check_val("redirect_pc",    bp_if.redirect_pc,    m_rpc);
        check_val("branch_cnt",     bp_if.branch_cnt,     m_bc);
        check_val("mispredict_cnt", bp_if.mispredict_cnt, m_mc);
    endtask

    task automatic set_if(input logic v, input logic br, input logic [31:0] pc);
        bp_if.if_valid = v; bp_if.if_is_branch = br; bp_if.if_pc = pc;
    endtask

    task automatic set_ex(input logic v, input logic br, input logic st, input logic [31:0] pc,
                          input logic pt, input logic bt, input logic [31:0] tgt);
        bp_if.ex_valid = v; bp_if.ex_is_branch = br; bp_if.ex_stall = st; bp_if.ex_pc = pc;
        bp_if.ex_pred_taken = pt; bp_if.ex_br_taken = bt; bp_if.ex_target = tgt;
    endtask

    // Called 1 time unit after a rising edge; checks prediction then registered outputs.
    task automatic cycle();
        #3;
        check_val("pred_taken", 32'(bp_if.pred_taken), 32'(m_pred()));
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    // Async reset asserted mid-cycle, table probed while held, released on falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < int'(ENTRIES); i++) begin
            set_if(1, 1, 32'(i * 4));
            #0.1;
            check_val("reset_table_pred", 32'(bp_if.pred_taken), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        set_if(0, 0, 0);
        set_ex(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        do_reset();

        // Reset state poll
        set_if(1, 1, 32'h40);
        cycle();
        check_val("t1_flush", 32'(bp_if.flush), 32'd0);

        // Three taken resolutions of 0x40 with stale not-taken prediction
        set_ex(1, 1, 0, 32'h40, 0, 1, 32'h100);
        cycle();
        check_val("t2_rv", 32'(bp_if.redirect_valid), 32'd1);
        check_val("t2_rpc", bp_if.redirect_pc, 32'h100);
        check_val("t2_flush1", 32'(bp_if.flush), 32'd1);
        cycle();
        check_val("t2_flush2", 32'(bp_if.flush), 32'd1);
        check_val("t2_rv2", 32'(bp_if.redirect_valid), 32'd0);
        check_val("t2_bc_hold", bp_if.branch_cnt, 32'd1);
        cycle();
        check_val("t2_idle", 32'(bp_if.flush), 32'd0);
        cycle();
        repeat (2) cycle();
        set_ex(1, 1, 0, 32'h40, 1, 1, 32'h100);
        cycle();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_val("t2_pred_sat", 32'(bp_if.pred_taken), 32'd1);
        check_val("t2_bc", bp_if.branch_cnt, 32'd3);

        // Saturate the top-of-memory entry, then mispredict not-taken with PC wrap
        set_ex(1, 1, 0, 32'hFFFF_FFFC, 1, 1, 32'h0);
        repeat (3) cycle();
        set_ex(1, 1, 0, 32'hFFFF_FFFC, 1, 0, 32'h1234);
        cycle();
        check_val("t3_rpc_wrap", bp_if.redirect_pc, 32'h0);
        check_val("t3_mc", bp_if.mispredict_cnt, 32'd3);
        set_ex(0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();
        set_if(1, 1, 32'hFFFF_FFFC);
        cycle();
        check_val("t3_ctr2_pred", 32'(bp_if.pred_taken), 32'd1);

        // Stalled branch in IDLE does nothing
        set_ex(1, 1, 1, 32'h40, 1, 0, 32'h0);
        cycle();
        check_val("t4_stall_bc", bp_if.branch_cnt, 32'd7);
        check_val("t4_stall_flush", 32'(bp_if.flush), 32'd0);

        // Reset while in FLUSH1
        set_ex(1, 1, 0, 32'h44, 0, 1, 32'h200);
        cycle();
        check_val("t6_pre_rv", 32'(bp_if.redirect_valid), 32'd1);
        #2;
        do_reset();

        // Same-cycle lookup and update of one entry
        set_if(1, 1, 32'h80);
        set_ex(1, 1, 0, 32'h80, 0, 1, 32'h300);
        #3;
        check_val("t5_pred_now", 32'(bp_if.pred_taken), 32'd0);
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_val("t5_pred_next", 32'(bp_if.pred_taken), 32'd1);

        // Randomized traffic with index aliasing and occasional resets
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ipc, epc;
            ipc = ($urandom_range(0, 9) == 0) ? $urandom : {$urandom_range(0, 3) * 32'h40, 6'd0} | 32'($urandom_range(0, 15) * 4);
            epc = ($urandom_range(0, 9) == 0) ? $urandom : {$urandom_range(0, 3) * 32'h40, 6'd0} | 32'($urandom_range(0, 15) * 4);
            set_if(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), ipc);
            set_ex(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 3) == 0), epc, 1'($urandom), 1'($urandom), $urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2;
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
